dac_stream_out: RTL

- Playback-side counterpart to the capture path: buffers Q1.15 samples from an upstream producer through a valid/ready FIFO.
- Emits them to the DAC at a programmable sample rate, one sample per tick.
- Runs entirely in the converter clock domain; upstream CDC, if any, is handled outside this block.
- Handles prefill, underrun recovery and status reporting.

---
 rtl/dac_pkg.sv | 6 +
 rtl/sync_fifo_ptr.sv | 34 +++
 rtl/dac_stream_out.sv | 84 ++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared sample type, playback state encoding and constants
package dac_pkg;
  typedef logic [15:0] sample_t;
  typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_RUN} state_t;
  localparam sample_t SAMPLE_ZERO = 16'h0000;
endpackage

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: single-clock FIFO with extra-bit pointers, registered level and flush
module sync_fifo_ptr #(
  parameter int DEPTH = 256,
  parameter int DATA_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [AW:0]       o_level
);
  logic [AW:0] r_wr, r_rd, r_level, w_wr_nx, w_rd_nx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  assign w_wr_nx = i_flush ? '0 : i_wr_en ? r_wr + 1'b1 : r_wr;
  assign w_rd_nx = i_flush ? '0 : i_rd_en ? r_rd + 1'b1 : r_rd;
  assign o_level = r_level;
  assign o_rd_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      r_wr <= w_wr_nx;
      r_rd <= w_rd_nx;
      r_level <= w_wr_nx - w_rd_nx;
    end
  always_ff @(posedge adc_clk)
    if (i_wr_en) r_mem[r_wr[AW-1:0]] <= i_wr_data;
endmodule

// File: rtl/dac_stream_out.sv
// dac_stream_out: buffered DAC playback with prefill, programmable sample rate and underrun status
module dac_stream_out
  import dac_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DATA_W = 16,
  parameter int PREFILL = 64,
  parameter int DIV = 1,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_strobe,
  output logic [LW-1:0]     level,
  output logic              running,
  output logic              underrun,
  output logic [15:0]       underrun_cnt,
  input  logic              clear_status
);
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [DATA_W-1:0] r_dac, w_rd_data;
  logic [LW-1:0] w_level;
  logic [15:0] r_ucnt;
  logic r_strobe, r_und, w_push, w_tick, w_pop, w_under;
  sync_fifo_ptr #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .adc_clk(adc_clk),
    .rst_n(rst_n),
    .i_flush(!enable),
    .i_wr_en(w_push),
    .i_wr_data(in_data),
    .i_rd_en(w_pop),
    .o_rd_data(w_rd_data),
    .o_level(w_level)
  );
  assign in_ready = r_state != S_IDLE && w_level != LW'(DEPTH);
  assign w_push = in_valid && in_ready;
  // a tick while enable is low is discarded along with the buffered samples
  assign w_tick = enable && r_state == S_RUN && r_cnt == CW'(DIV - 1);
  assign w_pop = w_tick && w_level != '0;
  assign w_under = w_tick && w_level == '0;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = !enable ? S_IDLE
               : r_state == S_IDLE ? S_PREFILL
               : r_state == S_PREFILL && w_level >= LW'(PREFILL) ? S_RUN
               : w_under ? S_PREFILL
               : r_state;
  end
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_dac <= DATA_W'(SAMPLE_ZERO);
      r_strobe <= 1'b0;
      r_und <= 1'b0;
      r_ucnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= (r_state != S_RUN || !enable || w_tick) ? '0 : r_cnt + 1'b1;
      r_strobe <= w_tick;
      r_dac <= (!enable || w_under) ? DATA_W'(SAMPLE_ZERO) : w_pop ? w_rd_data : r_dac;
      // a fresh underrun beats a simultaneous clear
      if (w_under) begin
        r_und <= 1'b1;
        r_ucnt <= clear_status ? 16'd1 : r_ucnt + 16'(r_ucnt != 16'hFFFF);
      end else if (clear_status) begin
        r_und <= 1'b0;
        r_ucnt <= '0;
      end
    end
  assign dac_data = r_dac;
  assign dac_strobe = r_strobe;
  assign level = w_level;
  assign running = r_state == S_RUN;
  assign underrun = r_und;
  assign underrun_cnt = r_ucnt;
endmodule
